// File: rtl/pip_ma_lsu_if.sv
// Bus bundle for the memory-access load/store unit: EX request side, data-cache port and writeback.
// The slave modport is the LSU view; master is the surrounding pipeline/cache view.
interface pip_ma_lsu_if #(
    parameter int unsigned XLEN = 32
) ();
    logic              iVALID;
    logic              oREADY;
    logic              iWE;
    logic [1:0]        iSIZE;
    logic              iUNS;
    logic [XLEN-1:0]   iADDR;
    logic [XLEN-1:0]   iWDATA;
    logic [4:0]        iDregADDR;

    logic              oMREQ;
    logic              iMGNT;
    logic              oMWE;
    logic [XLEN-1:0]   oMADDR;
    logic [XLEN/8-1:0] oMBE;
    logic [XLEN-1:0]   oMWDATA;
    logic              iMRVALID;
    logic [XLEN-1:0]   iMRDATA;
    logic              iMERR;

    logic              oWBVALID;
    logic [4:0]        oDregADDR;
    logic [XLEN-1:0]   oDregDATA;
    logic              oMISAL;
    logic              oBUSERR;

    modport slave (
        input  iVALID, iWE, iSIZE, iUNS, iADDR, iWDATA, iDregADDR,
        input  iMGNT, iMRVALID, iMRDATA, iMERR,
        output oREADY, oMREQ, oMWE, oMADDR, oMBE, oMWDATA,
        output oWBVALID, oDregADDR, oDregDATA, oMISAL, oBUSERR
    );

    modport master (
        output iVALID, iWE, iSIZE, iUNS, iADDR, iWDATA, iDregADDR,
        output iMGNT, iMRVALID, iMRDATA, iMERR,
        input  oREADY, oMREQ, oMWE, oMADDR, oMBE, oMWDATA,
        input  oWBVALID, oDregADDR, oDregDATA, oMISAL, oBUSERR
    );
endinterface

// File: rtl/pip_ma_lsu.sv
// Memory-access stage load/store unit: one request per handshake, lane-aligned cache access,
// load alignment/extension, misalignment and bus-error/timeout reporting. XLEN is 32 or 64.
module pip_ma_lsu #(
    parameter int unsigned XLEN    = 32,
    parameter int unsigned TIMEOUT = 16
) (
    input logic         iCLK,
    input logic         iRSTn,
    pip_ma_lsu_if.slave lsu_io
);
    localparam int unsigned NB     = XLEN / 8;
    localparam int unsigned OW     = $clog2(NB);
    localparam int unsigned CW     = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;
    localparam bit          HasDw  = (XLEN == 64);
    localparam bit          HasTmo = (TIMEOUT != 0);

    typedef enum logic [1:0] {StIdle, StReq, StResp} state_e;

    state_e          state_q, state_d;
    logic [CW-1:0]   cnt_q, cnt_d;
    logic [XLEN-1:0] maddr_q, maddr_d;
    logic [NB-1:0]   mbe_q, mbe_d;
    logic [XLEN-1:0] mwdata_q, mwdata_d;
    logic            mwe_q, mwe_d;
    logic [4:0]      rd_q, rd_d;
    logic [1:0]      size_q, size_d;
    logic            uns_q, uns_d;
    logic [OW-1:0]   off_q, off_d;
    logic            wbvalid_q, wbvalid_d;
    logic [4:0]      dreg_addr_q, dreg_addr_d;
    logic [XLEN-1:0] dreg_data_q, dreg_data_d;
    logic            misal_q, misal_d;
    logic            buserr_q, buserr_d;

    logic [OW-1:0]   off;
    logic            bad_access;
    logic [XLEN-1:0] rsh;
    logic [XLEN-1:0] ext;

    // Request-side decode of the incoming access.
    always_comb begin
        off        = lsu_io.iADDR[OW-1:0];
        bad_access = ((off & OW'((32'd1 << lsu_io.iSIZE) - 32'd1)) != '0) ||
                     ((lsu_io.iSIZE == 2'd3) && !HasDw);
    end

    // Load result: shift the addressed lanes down, then extend by access size.
    always_comb begin
        rsh = lsu_io.iMRDATA >> {off_q, 3'b000};
        ext = rsh;
        case (size_q)
            2'd0: begin
                if (uns_q) ext = XLEN'(rsh[7:0]);
                else       ext = XLEN'($signed(rsh[7:0]));
            end
            2'd1: begin
                if (uns_q) ext = XLEN'(rsh[15:0]);
                else       ext = XLEN'($signed(rsh[15:0]));
            end
            2'd2: begin
                if (uns_q) ext = XLEN'(rsh[31:0]);
                else       ext = XLEN'($signed(rsh[31:0]));
            end
            default: ext = rsh;
        endcase
    end

    always_comb begin
        state_d     = state_q;
        cnt_d       = cnt_q;
        maddr_d     = maddr_q;
        mbe_d       = mbe_q;
        mwdata_d    = mwdata_q;
        mwe_d       = mwe_q;
        rd_d        = rd_q;
        size_d      = size_q;
        uns_d       = uns_q;
        off_d       = off_q;
        dreg_addr_d = dreg_addr_q;
        dreg_data_d = dreg_data_q;
        wbvalid_d   = 1'b0;
        misal_d     = 1'b0;
        buserr_d    = 1'b0;

        unique case (state_q)
            StIdle: begin
                if (lsu_io.iVALID) begin
                    if (bad_access) begin
                        misal_d = 1'b1;
                    end else begin
                        state_d  = StReq;
                        maddr_d  = {lsu_io.iADDR[XLEN-1:OW], {OW{1'b0}}};
                        mbe_d    = NB'(((32'd1 << (32'd1 << lsu_io.iSIZE)) - 32'd1) << off);
                        mwdata_d = lsu_io.iWDATA << {off, 3'b000};
                        mwe_d    = lsu_io.iWE;
                        rd_d     = lsu_io.iDregADDR;
                        size_d   = lsu_io.iSIZE;
                        uns_d    = lsu_io.iUNS;
                        off_d    = off;
                    end
                end
            end
            StReq: begin
                // Responses are not expected before the grant, so iMRVALID is ignored here.
                if (lsu_io.iMGNT) begin
                    state_d = StResp;
                    cnt_d   = '0;
                end
            end
            StResp: begin
                if (lsu_io.iMRVALID) begin
                    state_d = StIdle;
                    if (lsu_io.iMERR) begin
                        buserr_d = 1'b1;
                    end else if (!mwe_q) begin
                        wbvalid_d   = 1'b1;
                        dreg_addr_d = rd_q;
                        dreg_data_d = (rd_q == 5'd0) ? '0 : ext;
                    end
                end else if (HasTmo && (cnt_q == CW'(TIMEOUT - 1))) begin
                    state_d  = StIdle;
                    buserr_d = 1'b1;
                end else begin
                    cnt_d = cnt_q + 1'b1;
                end
            end
            default: state_d = StIdle;
        endcase
    end

    always_ff @(posedge iCLK) begin
        if (!iRSTn) begin
            state_q     <= StIdle;
            cnt_q       <= '0;
            maddr_q     <= '0;
            mbe_q       <= '0;
            mwdata_q    <= '0;
            mwe_q       <= 1'b0;
            rd_q        <= '0;
            size_q      <= '0;
            uns_q       <= 1'b0;
            off_q       <= '0;
            wbvalid_q   <= 1'b0;
            dreg_addr_q <= '0;
            dreg_data_q <= '0;
            misal_q     <= 1'b0;
            buserr_q    <= 1'b0;
        end else begin
            state_q     <= state_d;
            cnt_q       <= cnt_d;
            maddr_q     <= maddr_d;
            mbe_q       <= mbe_d;
            mwdata_q    <= mwdata_d;
            mwe_q       <= mwe_d;
            rd_q        <= rd_d;
            size_q      <= size_d;
            uns_q       <= uns_d;
            off_q       <= off_d;
            wbvalid_q   <= wbvalid_d;
            dreg_addr_q <= dreg_addr_d;
            dreg_data_q <= dreg_data_d;
            misal_q     <= misal_d;
            buserr_q    <= buserr_d;
        end
    end

    assign lsu_io.oREADY    = (state_q == StIdle);
    assign lsu_io.oMREQ     = (state_q == StReq);
    assign lsu_io.oMWE      = mwe_q;
    assign lsu_io.oMADDR    = maddr_q;
    assign lsu_io.oMBE      = mbe_q;
    assign lsu_io.oMWDATA   = mwdata_q;
    assign lsu_io.oWBVALID  = wbvalid_q;
    assign lsu_io.oDregADDR = dreg_addr_q;
    assign lsu_io.oDregDATA = dreg_data_q;
    assign lsu_io.oMISAL    = misal_q;
    assign lsu_io.oBUSERR   = buserr_q;
endmodule

// File: tb/tb_pip_ma_lsu.sv
// Directed bench for pip_ma_lsu: vector table for single accesses on a 32-bit unit (TIMEOUT=4),
// hand sequences for stalls, errors, timeout and reset, plus doubleword/LWU on a 64-bit unit.
module tb_pip_ma_lsu;
    logic clk = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    pip_ma_lsu_if #(.XLEN(32)) b32 ();
    pip_ma_lsu_if #(.XLEN(64)) b64 ();

    pip_ma_lsu #(.XLEN(32), .TIMEOUT(4)) u32 (.iCLK(clk), .iRSTn(rst_n), .lsu_io(b32));
    pip_ma_lsu #(.XLEN(64), .TIMEOUT(16)) u64 (.iCLK(clk), .iRSTn(rst_n), .lsu_io(b64));

    int total = 0;
    int bad = 0;

    typedef struct {
        string       name;
        logic        we;
        logic [1:0]  size;
        logic        uns;
        logic [31:0] addr;
        logic [31:0] wdata;
        logic [4:0]  rd;
        logic [31:0] rdata;
        logic        e_misal;
        logic [3:0]  e_be;
        logic [31:0] e_maddr;
        logic [31:0] e_mwdata;
        logic        e_wb;
        logic [31:0] e_data;
    } vec_t;

    vec_t vecs [11];

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %h want %h", name, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic idle_inputs();
        b32.iVALID = 0; b32.iWE = 0; b32.iSIZE = 0; b32.iUNS = 0; b32.iADDR = 0;
        b32.iWDATA = 0; b32.iDregADDR = 0; b32.iMGNT = 0; b32.iMRVALID = 0;
        b32.iMRDATA = 0; b32.iMERR = 0;
        b64.iVALID = 0; b64.iWE = 0; b64.iSIZE = 0; b64.iUNS = 0; b64.iADDR = 0;
        b64.iWDATA = 0; b64.iDregADDR = 0; b64.iMGNT = 0; b64.iMRVALID = 0;
        b64.iMRDATA = 0; b64.iMERR = 0;
    endtask

    task automatic issue32(input logic we, input logic [1:0] size, input logic uns,
                           input logic [31:0] addr, input logic [31:0] wdata, input logic [4:0] rd);
        b32.iVALID = 1; b32.iWE = we; b32.iSIZE = size; b32.iUNS = uns;
        b32.iADDR = addr; b32.iWDATA = wdata; b32.iDregADDR = rd;
        tick();
        b32.iVALID = 0;
    endtask

    // Accept in cycle 0, grant in cycle 1, response in cycle 2, result/ready in cycle 3.
    task automatic run_vec(input vec_t v);
        issue32(v.we, v.size, v.uns, v.addr, v.wdata, v.rd);
        if (v.e_misal) begin
            check({v.name, " misal"}, 64'(b32.oMISAL), 64'd1);
            check({v.name, " no mreq"}, 64'(b32.oMREQ), 64'd0);
            check({v.name, " ready"}, 64'(b32.oREADY), 64'd1);
            tick();
            check({v.name, " misal pulse end"}, 64'(b32.oMISAL), 64'd0);
            check({v.name, " still no mreq"}, 64'(b32.oMREQ), 64'd0);
        end else begin
            check({v.name, " mreq"}, 64'(b32.oMREQ), 64'd1);
            check({v.name, " not ready"}, 64'(b32.oREADY), 64'd0);
            check({v.name, " mwe"}, 64'(b32.oMWE), 64'(v.we));
            check({v.name, " maddr"}, 64'(b32.oMADDR), 64'(v.e_maddr));
            check({v.name, " mbe"}, 64'(b32.oMBE), 64'(v.e_be));
            if (v.we) check({v.name, " mwdata"}, 64'(b32.oMWDATA), 64'(v.e_mwdata));
            b32.iMGNT = 1;
            tick();
            b32.iMGNT = 0;
            check({v.name, " mreq drop"}, 64'(b32.oMREQ), 64'd0);
            b32.iMRVALID = 1; b32.iMRDATA = v.rdata;
            tick();
            b32.iMRVALID = 0; b32.iMRDATA = 0;
            check({v.name, " wbvalid"}, 64'(b32.oWBVALID), 64'(v.e_wb));
            check({v.name, " ready back"}, 64'(b32.oREADY), 64'd1);
            check({v.name, " no buserr"}, 64'(b32.oBUSERR), 64'd0);
            if (v.e_wb) begin
                check({v.name, " rd"}, 64'(b32.oDregADDR), 64'(v.rd));
                check({v.name, " data"}, 64'(b32.oDregDATA), 64'(v.e_data));
            end
            tick();
            check({v.name, " wb pulse end"}, 64'(b32.oWBVALID), 64'd0);
        end
    endtask

    task automatic run64(input string name, input logic [1:0] size, input logic uns,
                         input logic [63:0] addr, input logic [63:0] rdata,
                         input logic [7:0] e_be, input logic [63:0] e_data);
        b64.iVALID = 1; b64.iWE = 0; b64.iSIZE = size; b64.iUNS = uns;
        b64.iADDR = addr; b64.iDregADDR = 5'd9;
        tick();
        b64.iVALID = 0;
        check({name, " mreq"}, 64'(b64.oMREQ), 64'd1);
        check({name, " maddr"}, b64.oMADDR, {addr[63:3], 3'b000});
        check({name, " mbe"}, 64'(b64.oMBE), 64'(e_be));
        b64.iMGNT = 1;
        tick();
        b64.iMGNT = 0;
        b64.iMRVALID = 1; b64.iMRDATA = rdata;
        tick();
        b64.iMRVALID = 0;
        check({name, " wbvalid"}, 64'(b64.oWBVALID), 64'd1);
        check({name, " data"}, b64.oDregDATA, e_data);
        tick();
    endtask

    initial begin
        vecs[0]  = '{"LB 103", 0, 2'd0, 0, 32'h103, 32'h0, 5'd5, 32'h80FF_1234,
                     0, 4'b1000, 32'h100, 32'h0, 1, 32'hFFFF_FF80};
        vecs[1]  = '{"LHU 102", 0, 2'd1, 1, 32'h102, 32'h0, 5'd6, 32'h8001_0000,
                     0, 4'b1100, 32'h100, 32'h0, 1, 32'h0000_8001};
        vecs[2]  = '{"LH 102", 0, 2'd1, 0, 32'h102, 32'h0, 5'd7, 32'h8001_0000,
                     0, 4'b1100, 32'h100, 32'h0, 1, 32'hFFFF_8001};
        vecs[3]  = '{"SB 201", 1, 2'd0, 0, 32'h201, 32'hAB, 5'd0, 32'h0,
                     0, 4'b0010, 32'h200, 32'h0000_AB00, 0, 32'h0};
        vecs[4]  = '{"SW 202", 1, 2'd2, 0, 32'h202, 32'h1234_5678, 5'd0, 32'h0,
                     1, 4'b0000, 32'h0, 32'h0, 0, 32'h0};
        vecs[5]  = '{"LW 204", 0, 2'd2, 0, 32'h204, 32'h0, 5'd31, 32'hDEAD_BEEF,
                     0, 4'b1111, 32'h204, 32'h0, 1, 32'hDEAD_BEEF};
        vecs[6]  = '{"LBU 101", 0, 2'd0, 1, 32'h101, 32'h0, 5'd3, 32'h1234_80CD,
                     0, 4'b0010, 32'h100, 32'h0, 1, 32'h0000_0080};
        vecs[7]  = '{"LB rd0", 0, 2'd0, 0, 32'h100, 32'h0, 5'd0, 32'h0000_00FF,
                     0, 4'b0001, 32'h100, 32'h0, 1, 32'h0};
        vecs[8]  = '{"LD rv32", 0, 2'd3, 0, 32'h0, 32'h0, 5'd1, 32'h0,
                     1, 4'b0000, 32'h0, 32'h0, 0, 32'h0};
        vecs[9]  = '{"SH 202", 1, 2'd1, 0, 32'h202, 32'h1234_5678, 5'd0, 32'h0,
                     0, 4'b1100, 32'h200, 32'h5678_0000, 0, 32'h0};
        vecs[10] = '{"LH 101", 0, 2'd1, 0, 32'h101, 32'h0, 5'd2, 32'h0,
                     1, 4'b0000, 32'h0, 32'h0, 0, 32'h0};

        idle_inputs();
        rst_n = 0;
        tick();
        tick();
        check("rst ready", 64'(b32.oREADY), 64'd1);
        check("rst mreq", 64'(b32.oMREQ), 64'd0);
        check("rst mwe", 64'(b32.oMWE), 64'd0);
        check("rst mbe", 64'(b32.oMBE), 64'd0);
        check("rst maddr", 64'(b32.oMADDR), 64'd0);
        check("rst mwdata", 64'(b32.oMWDATA), 64'd0);
        check("rst wbvalid", 64'(b32.oWBVALID), 64'd0);
        check("rst dreg addr", 64'(b32.oDregADDR), 64'd0);
        check("rst dreg data", 64'(b32.oDregDATA), 64'd0);
        check("rst misal", 64'(b32.oMISAL), 64'd0);
        check("rst buserr", 64'(b32.oBUSERR), 64'd0);
        rst_n = 1;
        tick();

        for (int i = 0; i < 11; i++) run_vec(vecs[i]);

        // Grant withheld for 5 cycles, then an error response.
        issue32(1'b0, 2'd2, 1'b0, 32'h300, 32'h0, 5'd4);
        for (int c = 0; c < 6; c++) begin
            check("stall mreq", 64'(b32.oMREQ), 64'd1);
            check("stall maddr", 64'(b32.oMADDR), 64'h300);
            check("stall mbe", 64'(b32.oMBE), 64'hF);
            if (c == 5) b32.iMGNT = 1;
            tick();
        end
        b32.iMGNT = 0;
        check("stall mreq drop", 64'(b32.oMREQ), 64'd0);
        b32.iMRVALID = 1; b32.iMERR = 1;
        tick();
        b32.iMRVALID = 0; b32.iMERR = 0;
        check("err buserr", 64'(b32.oBUSERR), 64'd1);
        check("err no wb", 64'(b32.oWBVALID), 64'd0);
        check("err ready", 64'(b32.oREADY), 64'd1);
        tick();
        check("err pulse end", 64'(b32.oBUSERR), 64'd0);

        // Timeout: four silent response cycles after the grant, then the error pulse.
        issue32(1'b0, 2'd2, 1'b0, 32'h400, 32'h0, 5'd8);
        b32.iMGNT = 1;
        tick();
        b32.iMGNT = 0;
        for (int c = 0; c < 4; c++) begin
            check("tmo wait no buserr", 64'(b32.oBUSERR), 64'd0);
            check("tmo wait busy", 64'(b32.oREADY), 64'd0);
            tick();
        end
        check("tmo buserr", 64'(b32.oBUSERR), 64'd1);
        check("tmo ready", 64'(b32.oREADY), 64'd1);
        b32.iMRVALID = 1; b32.iMRDATA = 32'h1111_1111;
        tick();
        b32.iMRVALID = 0;
        check("late rvalid no wb", 64'(b32.oWBVALID), 64'd0);
        check("late rvalid no buserr", 64'(b32.oBUSERR), 64'd0);
        run_vec(vecs[5]);

        // Reset while waiting for a response; a stale response afterwards is ignored.
        issue32(1'b0, 2'd2, 1'b0, 32'h500, 32'h0, 5'd10);
        b32.iMGNT = 1;
        tick();
        b32.iMGNT = 0;
        check("pre-rst busy", 64'(b32.oREADY), 64'd0);
        rst_n = 0;
        tick();
        rst_n = 1;
        check("mid-rst ready", 64'(b32.oREADY), 64'd1);
        check("mid-rst mreq", 64'(b32.oMREQ), 64'd0);
        b32.iMRVALID = 1; b32.iMRDATA = 32'h2222_2222;
        tick();
        b32.iMRVALID = 0;
        check("stale no wb", 64'(b32.oWBVALID), 64'd0);
        check("stale no buserr", 64'(b32.oBUSERR), 64'd0);
        check("stale dreg data", 64'(b32.oDregDATA), 64'd0);

        run64("LD 8", 2'd3, 1'b0, 64'h8, 64'h0123_4567_89AB_CDEF, 8'hFF, 64'h0123_4567_89AB_CDEF);
        run64("LWU 4", 2'd2, 1'b1, 64'h4, 64'h8765_4321_0000_0000, 8'hF0, 64'h0000_0000_8765_4321);
        run64("LW 4", 2'd2, 1'b0, 64'h4, 64'h8765_4321_0000_0000, 8'hF0, 64'hFFFF_FFFF_8765_4321);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
